// File: rtl/mux_scan_ctrl_if.sv
// rtl/mux_scan_ctrl_if.sv - handshake and mux-select bundle between scan controller and its environment
interface mux_scan_ctrl_if;
   logic       start;
   logic       y;
   logic       ack;
   logic [1:0] s;
   logic [3:0] data;
   logic       valid;
   logic       busy;

   modport master (output start, y, ack, input s, data, valid, busy);
   modport slave  (input start, y, ack, output s, data, valid, busy);
endinterface

// File: rtl/mux_scan_ctrl.sv
// rtl/mux_scan_ctrl.sv - steps a 4:1 mux select, waits SETTLE cycles per input, samples y into a 4-bit word
module mux_scan_ctrl #(
   parameter int SETTLE = 2
) (
   input  logic            clk,
   input  logic            rst,
   mux_scan_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_SAMPLE,
      ST_DONE
   } state_t;

   localparam logic [3:0] CNT_LOAD = 4'(SETTLE - 1);

   state_t     state, state_n;
   logic [3:0] cnt, cnt_n;
   logic [1:0] s_q, s_n;
   logic [3:0] shadow, shadow_n;
   logic [3:0] data_q, data_n;
   logic       valid_q, valid_n;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_IDLE;
         cnt     <= 4'd0;
         s_q     <= 2'd0;
         shadow  <= 4'd0;
         data_q  <= 4'd0;
         valid_q <= 1'b0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         s_q     <= s_n;
         shadow  <= shadow_n;
         data_q  <= data_n;
         valid_q <= valid_n;
      end
   end

   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      s_n      = s_q;
      shadow_n = shadow;
      data_n   = data_q;
      valid_n  = valid_q;
      case (state)
         ST_IDLE: begin
            if (bus.start) begin
               state_n  = ST_SETTLE;
               s_n      = 2'd0;
               cnt_n    = CNT_LOAD;
               shadow_n = 4'd0;
            end
         end
         ST_SETTLE: begin
            if (cnt == 4'd0) state_n = ST_SAMPLE;
            else             cnt_n   = cnt - 4'd1;
         end
         ST_SAMPLE: begin
            shadow_n[s_q] = bus.y;
            if (s_q != 2'd3) begin
               s_n     = s_q + 2'd1;
               cnt_n   = CNT_LOAD;
               state_n = ST_SETTLE;
            end else begin
               // publish the whole word at once so data never shows a partial scan
               state_n = ST_DONE;
               data_n  = shadow_n;
               valid_n = 1'b1;
            end
         end
         ST_DONE: begin
            if (bus.ack) begin
               state_n = ST_IDLE;
               valid_n = 1'b0;
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   assign bus.s     = s_q;
   assign bus.data  = data_q;
   assign bus.valid = valid_q;
   assign bus.busy  = (state == ST_SETTLE) || (state == ST_SAMPLE);

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb/tb_mux_scan_ctrl.sv - self-checking bench for mux_scan_ctrl with SETTLE=2 and SETTLE=1 instances
module tb_mux_scan_ctrl;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mux_scan_ctrl_if ifc2();
   mux_scan_ctrl_if ifc1();
   logic [3:0] mux2, mux1;

   assign ifc2.y = mux2[ifc2.s];
   assign ifc1.y = mux1[ifc1.s];

   mux_scan_ctrl #(.SETTLE(2)) u_dut2 (.clk(clk), .rst(rst), .bus(ifc2.slave));
   mux_scan_ctrl #(.SETTLE(1)) u_dut1 (.clk(clk), .rst(rst), .bus(ifc1.slave));

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [3:0] i;
      logic [3:0] exp_data;
   } vec_t;
   vec_t tab[6];

   logic [3:0] hist[0:12];
   logic [3:0] exp_word;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic start_scan2();
      ifc2.start = 1'b1;
      step();
      ifc2.start = 1'b0;
   endtask

   task automatic wait_valid2(input int limit, output int n);
      n = 0;
      while (!ifc2.valid && n < limit) begin
         step();
         n++;
      end
   endtask

   task automatic ack2();
      ifc2.ack = 1'b1;
      step();
      ifc2.ack = 1'b0;
   endtask

   initial begin
      int n;
      tab[0] = '{4'b1010, 4'b1010};
      tab[1] = '{4'b0000, 4'b0000};
      tab[2] = '{4'b1111, 4'b1111};
      tab[3] = '{4'b0101, 4'b0101};
      tab[4] = '{4'b1000, 4'b1000};
      tab[5] = '{4'b0001, 4'b0001};

      rst = 1'b1;
      ifc2.start = 1'b0; ifc2.ack = 1'b0;
      ifc1.start = 1'b0; ifc1.ack = 1'b0;
      mux2 = 4'd0; mux1 = 4'd0;
      step(); step();
      chk("rst_s", ifc2.s, 0);
      chk("rst_data", ifc2.data, 0);
      chk("rst_valid", ifc2.valid, 0);
      chk("rst_busy", ifc2.busy, 0);
      chk("rst_busy1", ifc1.busy, 0);
      rst = 1'b0;
      step();
      chk("post_rst_idle", ifc2.busy, 0);

      // scan of 1010: select steps every SETTLE+1 cycles, valid at edge 12
      mux2 = 4'b1010;
      start_scan2();
      for (int k = 0; k < 12; k++) begin
         chk("seq_s", ifc2.s, k / 3);
         chk("seq_busy", ifc2.busy, 1);
         chk("seq_valid_early", ifc2.valid, 0);
         step();
      end
      chk("seq_valid", ifc2.valid, 1);
      chk("seq_data", ifc2.data, 4'b1010);
      chk("seq_busy_done", ifc2.busy, 0);
      chk("seq_s_done", ifc2.s, 3);

      // long hold without ack
      for (int k = 0; k < 20; k++) begin
         step();
         chk("hold_valid", ifc2.valid, 1);
         chk("hold_data", ifc2.data, 4'b1010);
      end
      ack2();
      chk("ack_valid", ifc2.valid, 0);
      chk("ack_busy", ifc2.busy, 0);
      chk("ack_data", ifc2.data, 4'b1010);
      chk("ack_s", ifc2.s, 3);
      step();
      chk("idle_stays", ifc2.busy, 0);

      // table of patterns
      for (int k = 0; k < 6; k++) begin
         mux2 = tab[k].i;
         start_scan2();
         wait_valid2(20, n);
         chk("tab_latency", n, 12);
         chk("tab_data", ifc2.data, tab[k].exp_data);
         chk("tab_busy", ifc2.busy, 0);
         ack2();
         chk("tab_ack_valid", ifc2.valid, 0);
      end

      // start noise mid-scan and ack during SETTLE are ignored
      mux2 = 4'b0110;
      start_scan2();
      for (int k = 1; k <= 12; k++) begin
         ifc2.start = (k == 3 || k == 7);
         ifc2.ack   = (k == 1);
         step();
         ifc2.start = 1'b0;
         ifc2.ack   = 1'b0;
         if (k < 12) begin
            chk("noise_s", ifc2.s, k / 3);
            chk("noise_valid", ifc2.valid, 0);
         end
      end
      chk("noise_valid_at12", ifc2.valid, 1);
      chk("noise_data", ifc2.data, 4'b0110);
      step();
      chk("noise_ack_not_kept", ifc2.valid, 1);
      ack2();

      // asynchronous reset mid-scan
      mux2 = 4'b1111;
      start_scan2();
      for (int k = 0; k < 6; k++) step();
      #1 rst = 1'b1;
      #1;
      chk("arst_s", ifc2.s, 0);
      chk("arst_data", ifc2.data, 0);
      chk("arst_valid", ifc2.valid, 0);
      chk("arst_busy", ifc2.busy, 0);
      @(negedge clk);
      rst = 1'b0;
      step();
      chk("arst_idle", ifc2.busy, 0);
      start_scan2();
      wait_valid2(20, n);
      chk("arst_rescan_latency", n, 12);
      chk("arst_rescan_data", ifc2.data, 4'b1111);
      ack2();

      // SETTLE=1: input changes right after the s=1 sample
      mux1 = 4'b0000;
      ifc1.start = 1'b1;
      step();
      ifc1.start = 1'b0;
      for (int k = 0; k < 4; k++) step();
      mux1 = 4'b1111;
      n = 4;
      while (!ifc1.valid && n < 20) begin
         step();
         n++;
      end
      chk("s1_latency", n, 8);
      chk("s1_data", ifc1.data, 4'b1100);
      ifc1.ack = 1'b1;
      step();
      ifc1.ack = 1'b0;
      chk("s1_ack", ifc1.valid, 0);

      // ack and start together in DONE
      mux2 = 4'b0011;
      start_scan2();
      wait_valid2(20, n);
      chk("both_latency", n, 12);
      ifc2.ack = 1'b1;
      ifc2.start = 1'b1;
      step();
      ifc2.ack = 1'b0;
      ifc2.start = 1'b0;
      chk("both_valid", ifc2.valid, 0);
      chk("both_busy", ifc2.busy, 0);
      step();
      chk("both_no_scan", ifc2.busy, 0);
      start_scan2();
      chk("both_restart_busy", ifc2.busy, 1);
      wait_valid2(20, n);
      chk("both_restart_latency", n, 12);
      chk("both_restart_data", ifc2.data, 4'b0011);
      ack2();

      // randomized: mux input changes every cycle; bit k is whatever I[k] was at edge 3*(k+1)
      for (int r = 0; r < 25; r++) begin
         for (int g = 0, gl = $urandom_range(0, 3); g < gl; g++) begin
            ifc2.ack = 1'($urandom);
            step();
         end
         ifc2.ack = 1'b0;
         mux2 = 4'($urandom);
         start_scan2();
         for (int k = 1; k <= 12; k++) begin
            mux2 = 4'($urandom);
            hist[k] = mux2;
            ifc2.start = 1'($urandom);
            ifc2.ack   = 1'($urandom);
            step();
            chk("rnd_valid_timing", ifc2.valid, (k == 12));
         end
         ifc2.start = 1'b0;
         ifc2.ack   = 1'b0;
         for (int k = 0; k < 4; k++) exp_word[k] = hist[3 * (k + 1)][k];
         chk("rnd_data", ifc2.data, exp_word);
         chk("rnd_busy", ifc2.busy, 0);
         for (int g = 0, gl = $urandom_range(0, 3); g < gl; g++) begin
            ifc2.start = 1'($urandom);
            step();
            chk("rnd_hold", ifc2.valid, 1);
         end
         ifc2.start = 1'b0;
         ack2();
         chk("rnd_ack", ifc2.valid, 0);
         chk("rnd_keep_data", ifc2.data, exp_word);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mux_scan_ctrl.md
MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 The block SHALL have parameter SETTLE, default 2, the number of wait cycles after each select change before sampling; legal range 1..15.
REQ-002 Port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 Port rst  input  1  asynchronous, active-high reset.
REQ-004 Port start  input  1  scan request, sampled only in IDLE.
REQ-005 Port y  input  1  output of the downstream 4:1 mux (y = I[s]).
REQ-006 Port ack  input  1  consumer acknowledge of a completed scan.
REQ-007 Port s  output  2  select driven to the 4:1 mux; registered.
REQ-008 Port data  output  4  scanned word, bit k = y sampled while s = k; registered.
REQ-009 Port valid  output  1  data holds a completed scan that has not yet been acknowledged.
REQ-010 Port busy  output  1  a scan is in progress (SETTLE or SAMPLE state).

Function
REQ-011 The FSM SHALL have exactly the states IDLE, SETTLE, SAMPLE and DONE.
REQ-012 In IDLE with start=1, the FSM SHALL move to SETTLE, set s=0, load the wait counter with SETTLE-1, and clear the internal shadow word.
REQ-013 In SETTLE, the counter SHALL decrement each cycle; at counter 0 the FSM SHALL move to SAMPLE, so SETTLE lasts exactly SETTLE cycles.
REQ-014 In SAMPLE, the block SHALL write y into shadow bit s; if s<3, it SHALL set s=s+1, reload the counter and return to SETTLE; if s=3, it SHALL go to DONE.
REQ-015 On entry to DONE, data SHALL load the full shadow word and valid SHALL go to 1 in the same edge; data never shows a partial scan.
REQ-016 In DONE, valid SHALL stay 1 until ack=1 is sampled, then the FSM SHALL go to IDLE with valid=0; data SHALL keep its value.
REQ-017 Latency: with start sampled at edge E0, valid SHALL rise at edge E0+4*(SETTLE+1), which is edge 12 for SETTLE=2.
REQ-018 busy SHALL be 1 exactly while in SETTLE or SAMPLE; valid and busy SHALL never both be 1.
REQ-019 start outside IDLE SHALL be ignored, including start=1 on the ack cycle in DONE; a new scan needs start re-sampled in IDLE.
REQ-020 ack outside DONE SHALL be ignored and SHALL NOT be remembered.
REQ-021 s SHALL wrap only by returning to 0 at the next scan start; s SHALL hold 3 in DONE and in IDLE after a completed scan.
REQ-022 Each y sample SHALL use only the settled value for the current s; y SHALL NOT be sampled in the same cycle s changes.

Reset
REQ-023 While rst=1, the block SHALL immediately (asynchronously) force state IDLE, s=0, data=0, valid=0, busy=0, counter=0 and shadow=0.
REQ-024 Reset asserted mid-scan or in DONE SHALL discard the partial or pending result with no output glitch to a non-reset value.
REQ-025 After rst deasserts, the block SHALL stay in IDLE until start=1 is sampled on a rising clk edge.

Verification
REQ-026 Mux model I=4'b1010, SETTLE=2, start pulsed 1 cycle -> s steps 0,1,2,3 every 3 cycles; valid=1 and data=4'b1010 at edge 12; busy=0 then.
REQ-027 Hold ack=0 for 20 cycles after valid, then pulse ack -> valid stays 1 and data stays stable throughout; next edge: valid=0, IDLE, data still 4'b1010.
REQ-028 Pulse start at cycles 3 and 7 of a running scan, and pulse ack during SETTLE -> no restart, unchanged timing, result = I at the sampling instants.
REQ-029 Assert rst at cycle 6 of a scan with I=4'b1111 -> s=0, data=0, valid=0 and busy=0 without waiting for a clock edge; a new start gives data=4'b1111 at +12.
REQ-030 Change I from 4'b0000 to 4'b1111 right after the s=1 sample, with SETTLE=1 -> data=4'b1100, valid at edge 8.
REQ-031 In DONE drive ack=1 and start=1 together -> returns to IDLE with no new scan; start on the next cycle begins a scan normally.
